// File: rtl/tern_loader_pkg.sv
// Shared definitions for the host-to-board program loader: RX/packet state
// encodings, default sync marker, bit-timing and checksum helpers.
package tern_loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        R_IDLE  = 3'd0,
        R_START = 3'd1,
        R_DATA  = 3'd2,
        R_STOP  = 3'd3,
        R_BREAK = 3'd4
    } rx_state_e;

    typedef enum logic [1:0] {
        P_SYNC  = 2'd0,
        P_LEN   = 2'd1,
        P_DATA  = 2'd2,
        P_CKSUM = 2'd3
    } pkt_state_e;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic logic [7:0] sum8_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, mid-bit sampling, glitch reject on
// the start bit and break hold after a framing error.
module uart_rx_byte
    import tern_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta_q, rx_sync_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;

    // Two-stage synchronizer, idles high
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= R_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'd0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Next-state: start-bit qualification, data shift, stop-bit check
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            R_IDLE: begin
                cnt_d = '0;
                if (!rx_sync_q) state_d = R_START;
                else            state_d = R_IDLE;
            end
            R_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    if (!rx_sync_q) state_d = R_DATA;
                    else            state_d = R_IDLE;
                end else begin
                    state_d = R_START;
                end
            end
            R_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = R_STOP;
                    else                   state_d = R_DATA;
                end else begin
                    state_d = R_DATA;
                end
            end
            R_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                        state_d      = R_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = R_BREAK;
                    end
                end else begin
                    state_d = R_STOP;
                end
            end
            R_BREAK: begin
                cnt_d = '0;
                if (rx_sync_q) state_d = R_IDLE;
                else           state_d = R_BREAK;
            end
            default: begin
                cnt_d   = '0;
                state_d = R_IDLE;
            end
        endcase
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = byte_valid_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: decodes SYNC/LEN/DATA[/CKSUM] packets into program-memory
// writes. Checksum byte and its check are present only when LOADER_CKSUM_EN is defined.
module uart_prog_loader
    import tern_loader_pkg::*;
#(
    parameter int         CLK_HZ       = 12000000,
    parameter int         BAUD         = 9600,
    parameter int         ADDR_W       = 8,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_BITS = 40
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              uart_rx,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [7:0]        prog_data,
    output logic              loading,
    output logic              load_done,
    output logic              load_err
);

    localparam int CPB     = clks_per_bit(CLK_HZ, BAUD);
    localparam int MAX_LEN = (ADDR_W >= 8) ? 256 : (1 << ADDR_W);
    localparam int TMO_CYC = TIMEOUT_BITS * CPB;
    localparam int TMO_W   = $clog2(TMO_CYC + 1);

    logic [7:0] rx_byte_s;
    logic       byte_valid_s, frame_err_s;
    logic [8:0] len_raw_s, len_cap_s;

    pkt_state_e        state_q, state_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [8:0]        len_q, len_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              prog_we_q, prog_we_d;
    logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
    logic [7:0]        prog_data_q, prog_data_d;
    logic              loading_q, loading_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef LOADER_CKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) u_rx (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .rx_i        (uart_rx),
        .byte_o      (rx_byte_s),
        .byte_valid_o(byte_valid_s),
        .frame_err_o (frame_err_s)
    );

    // LEN of zero means a full 256-byte image, capped to the address space
    assign len_raw_s = (rx_byte_s == 8'd0) ? 9'd256 : {1'b0, rx_byte_s};
    assign len_cap_s = (len_raw_s > 9'(MAX_LEN)) ? 9'(MAX_LEN) : len_raw_s;

    // Packet state and registered outputs
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= P_SYNC;
            cnt_q       <= 9'd0;
            len_q       <= 9'd0;
            tmo_q       <= '0;
            prog_we_q   <= 1'b0;
            prog_addr_q <= '0;
            prog_data_q <= 8'd0;
            loading_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef LOADER_CKSUM_EN
            sum_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            tmo_q       <= tmo_d;
            prog_we_q   <= prog_we_d;
            prog_addr_q <= prog_addr_d;
            prog_data_q <= prog_data_d;
            loading_q   <= loading_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef LOADER_CKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    // Packet decoding; a received byte takes priority over a same-cycle timeout
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        prog_we_d   = 1'b0;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;
        loading_d   = loading_q;
        done_d      = 1'b0;
        err_d       = err_q;
        tmo_d       = (state_q == P_SYNC) ? '0 : tmo_q + TMO_W'(1);
`ifdef LOADER_CKSUM_EN
        sum_d       = sum_q;
`endif
        if (state_q == P_SYNC) begin
            if (byte_valid_s && (rx_byte_s == SYNC_BYTE)) begin
                state_d   = P_LEN;
                loading_d = 1'b1;
                err_d     = 1'b0;
                cnt_d     = 9'd0;
`ifdef LOADER_CKSUM_EN
                sum_d     = 8'd0;
`endif
            end else begin
                state_d = P_SYNC;
            end
        end else if (byte_valid_s) begin
            tmo_d = '0;
            case (state_q)
                P_LEN: begin
                    len_d   = len_cap_s;
                    state_d = P_DATA;
                end
                P_DATA: begin
                    prog_we_d   = 1'b1;
                    prog_addr_d = ADDR_W'(cnt_q);
                    prog_data_d = rx_byte_s;
                    cnt_d       = cnt_q + 9'd1;
`ifdef LOADER_CKSUM_EN
                    sum_d       = sum8_add(sum_q, rx_byte_s);
                    if (cnt_q == len_q - 9'd1) state_d = P_CKSUM;
                    else                       state_d = P_DATA;
`else
                    if (cnt_q == len_q - 9'd1) begin
                        done_d    = 1'b1;
                        loading_d = 1'b0;
                        state_d   = P_SYNC;
                    end else begin
                        state_d = P_DATA;
                    end
`endif
                end
                P_CKSUM: begin
`ifdef LOADER_CKSUM_EN
                    if (rx_byte_s == sum_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
`else
                    err_d = 1'b1;
`endif
                    loading_d = 1'b0;
                    state_d   = P_SYNC;
                end
                default: begin
                    loading_d = 1'b0;
                    state_d   = P_SYNC;
                end
            endcase
        end else if (frame_err_s || (tmo_q == TMO_W'(TMO_CYC - 1))) begin
            err_d     = 1'b1;
            loading_d = 1'b0;
            state_d   = P_SYNC;
        end else begin
            state_d = state_q;
        end
    end

    assign prog_we   = prog_we_q;
    assign prog_addr = prog_addr_q;
    assign prog_data = prog_data_q;
    assign loading   = loading_q;
    assign load_done = done_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed + randomized bench for uart_prog_loader with a packet-level reference model.
module tb_uart_prog_loader;

    localparam int         CLK_HZ = 115200;
    localparam int         BAUD   = 9600;
    localparam int         CPB    = CLK_HZ / BAUD;
    localparam int         ADDR_W = 8;
    localparam logic [7:0] SYNC   = 8'hA5;
`ifdef LOADER_CKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic              clk_in  = 1'b0;
    logic              rst_n   = 1'b0;
    logic              uart_rx = 1'b1;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [7:0]        prog_data;
    logic              loading, load_done, load_err;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t wr_q[$];
    int  done_cnt = 0;
    int  bv_cnt   = 0;
    int  pass_cnt = 0;
    int  tot_cnt  = 0;

    always #5 clk_in = ~clk_in;

    uart_prog_loader #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W), .SYNC_BYTE(SYNC), .TIMEOUT_BITS(40)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .uart_rx(uart_rx),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .loading(loading), .load_done(load_done), .load_err(load_err)
    );

    always @(negedge clk_in) begin
        if (prog_we) wr_q.push_back('{addr: prog_addr, data: prog_data});
        if (load_done) done_cnt++;
        if (dut.u_rx.byte_valid_o) bv_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Serial frame; rst_bit >= 0 pulses rst_n for 2 cycles in the middle of that bit
    task automatic send_byte(input logic [7:0] b, input logic stop, input int rst_bit);
        logic v;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      v = 1'b0;
            else if (i == 9) v = stop;
            else             v = b[i-1];
            uart_rx = v;
            if (i == rst_bit) begin
                cyc(CPB / 2);
                rst_n = 1'b0;
                #1;
                chk("rst_loading_now", loading, 0);
                chk("rst_we_now", prog_we, 0);
                cyc(2);
                uart_rx = 1'b1;
                rst_n   = 1'b1;
                return;
            end
            cyc(CPB);
        end
    endtask

    // Send a full packet and compare against expected writes/done/err
    task automatic run_pkt(input string tag, input logic [7:0] d[$], input bit good_ck);
        int         n = d.size();
        int         done0 = done_cnt;
        int         sum = 0;
        bit         ok;
        logic [7:0] ck;
        foreach (d[i]) sum = (sum + d[i]) % 256;
        ck = good_ck ? 8'(sum) : 8'(sum + 1);
        ok = !CK_EN || good_ck;
        wr_q.delete();
        send_byte(SYNC, 1'b1, -1);
        send_byte(8'(n % 256), 1'b1, -1);
        foreach (d[i]) send_byte(d[i], 1'b1, -1);
        if (CK_EN) send_byte(ck, 1'b1, -1);
        cyc(CPB);
        chk({tag, "_nwr"}, wr_q.size(), n);
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            chk({tag, "_addr"}, wr_q[i].addr, i % 256);
            chk({tag, "_data"}, wr_q[i].data, d[i]);
        end
        chk({tag, "_done"}, done_cnt - done0, ok ? 1 : 0);
        chk({tag, "_err"}, load_err, ok ? 0 : 1);
        chk({tag, "_loading"}, loading, 0);
    endtask

    initial begin
        logic [7:0] pk[$];
        int         bv0, done0;

        // reset state
        cyc(3);
        chk("rst_we", prog_we, 0);
        chk("rst_addr", prog_addr, 0);
        chk("rst_data", prog_data, 0);
        chk("rst_loading", loading, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_err, 0);
        rst_n = 1'b1;

        // idle line outside a packet never errors
        cyc(50 * CPB);
        chk("idle_err", load_err, 0);
        chk("idle_loading", loading, 0);

        // basic packet (checksum 66 when enabled)
        pk = {8'h11, 8'h22, 8'h33};
        run_pkt("t1", pk, 1'b1);

        // bad checksum (plain packet when checksum disabled)
        run_pkt("t2", pk, 1'b0);

        // glitch on idle line
        bv0 = bv_cnt;
        uart_rx = 1'b0;
        cyc(2);
        uart_rx = 1'b1;
        cyc(3 * CPB);
        chk("glitch_bv", bv_cnt - bv0, 0);
        chk("glitch_loading", loading, 0);

        // framing error on second data byte, then break
        wr_q.delete();
        send_byte(SYNC, 1'b1, -1);
        send_byte(8'h03, 1'b1, -1);
        send_byte(8'h5A, 1'b1, -1);
        send_byte(8'hC3, 1'b0, -1);
        bv0 = bv_cnt;
        uart_rx = 1'b0;
        cyc(30 * CPB);
        chk("brk_bv_low", bv_cnt - bv0, 0);
        uart_rx = 1'b1;
        cyc(2 * CPB);
        chk("brk_bv_after", bv_cnt - bv0, 0);
        chk("fe_nwr", wr_q.size(), 1);
        chk("fe_err", load_err, 1);
        chk("fe_loading", loading, 0);
        send_byte(SYNC, 1'b1, -1);
        cyc(2);
        chk("resync_err_clr", load_err, 0);
        chk("resync_loading", loading, 1);
        done0 = done_cnt;
        send_byte(8'h01, 1'b1, -1);
        send_byte(8'h77, 1'b1, -1);
        if (CK_EN) send_byte(8'h77, 1'b1, -1);
        cyc(CPB);
        chk("resync_done", done_cnt - done0, 1);

        // timeout after LEN
        send_byte(SYNC, 1'b1, -1);
        send_byte(8'h02, 1'b1, -1);
        cyc(38 * CPB);
        chk("tmo_before_loading", loading, 1);
        chk("tmo_before_err", load_err, 0);
        cyc(3 * CPB);
        chk("tmo_err", load_err, 1);
        chk("tmo_loading", loading, 0);

        // reset during second data byte
        wr_q.delete();
        done0 = done_cnt;
        send_byte(SYNC, 1'b1, -1);
        send_byte(8'h05, 1'b1, -1);
        send_byte(8'h3C, 1'b1, -1);
        send_byte(8'h4D, 1'b1, 4);
        cyc(3 * CPB);
        chk("rstmid_loading", loading, 0);
        chk("rstmid_err", load_err, 0);
        chk("rstmid_done", done_cnt - done0, 0);
        chk("rstmid_nwr", wr_q.size(), 1);
        pk = {8'hE1, 8'h02};
        run_pkt("after_rst", pk, 1'b1);

        // randomized packets, SYNC value allowed inside data
        for (int k = 0; k < 4; k++) begin
            int n = $urandom_range(1, 8);
            pk.delete();
            for (int i = 0; i < n; i++) pk.push_back(8'($urandom));
            if (k == 0) pk[0] = SYNC;
            run_pkt("rand", pk, $urandom_range(0, 2) != 0);
        end

        // N=0 -> 256 writes, address wraps at 255
        pk.delete();
        for (int i = 0; i < 256; i++) pk.push_back(8'($urandom));
        run_pkt("n256", pk, 1'b1);
        chk("n256_last_addr", wr_q.size() == 256 ? wr_q[255].addr : 8'h00, 8'hFF);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
